// File: rtl/probe_stamp_if.sv
// Word-stream link used on both sides of probe_stamp: {ctrl,data} with a
// write strobe from the sender and a ready flag from the receiver.
interface probe_stamp_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/probe_stamp.sv
// probe_stamp: pass-through stage that overwrites one payload word of each
// probe packet with the cycle count captured when the packet's IO-queue
// header left the stage. A 4-entry fall-through FIFO decouples upstream.
//
// state | meaning
// HDRS  | expecting module header words (ctrl != 0) or data word 0
// DATA  | inside the payload, counting data words until EOP (ctrl != 0)
module probe_stamp #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [15:0]           PROBE_DST  = 16'h0005,
  parameter logic [CTRL_WIDTH-1:0] HDR_CTRL   = 8'hFF,
  parameter int                    STAMP_WORD = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  probe_stamp_if.slave         upstream,
  probe_stamp_if.master        downstream,
  input  logic                 stamp_en,
  output logic [31:0]          stamp_cnt,
  output logic [63:0]          last_stamp
);

  localparam logic [0:0] HDRS = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  logic [63:0]           ts_cnt;
  logic [63:0]           ts_hold;
  logic [0:0]            state;
  logic                  probe;
  logic [7:0]            word_idx;
  logic [7:0]            cur_idx;
  logic                  stamp_hit;

  assign fifo_empty   = (fifo_count == 3'd0);
  assign fifo_full    = (fifo_count == 3'd4);
  // The 4th entry absorbs one in-flight write after rdy drops at 3 entries.
  assign upstream.rdy = reset_n && (fifo_count < 3'd3);
  assign push         = upstream.wr && !fifo_full;
  assign pop          = !fifo_empty && downstream.rdy;
  assign {head_ctrl, head_data} = fifo_mem[rd_ptr];

  // Word 0 can arrive while still in HDRS, so the index there is 0.
  assign cur_idx   = (state == HDRS) ? 8'd0 : word_idx;
  assign stamp_hit = pop && (head_ctrl == '0) && (cur_idx == 8'(STAMP_WORD))
                     && probe && stamp_en;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {upstream.ctrl, upstream.data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
    end
  end

  // Free-running cycle timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 64'd1;
  end

  // Packet parser, advanced only by words actually leaving the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HDRS;
      probe    <= 1'b0;
      ts_hold  <= '0;
      word_idx <= '0;
    end else if (pop) begin
      case (state)
        HDRS: begin
          if (head_ctrl != '0) begin
            if (head_ctrl == HDR_CTRL) begin
              probe   <= (head_data[DATA_WIDTH-1 -: 16] == PROBE_DST);
              ts_hold <= ts_cnt;
            end
          end else begin
            state    <= DATA;
            word_idx <= 8'd1;
          end
        end
        DATA: begin
          if (head_ctrl == '0) begin
            if (word_idx != 8'hFF) word_idx <= word_idx + 8'd1;
          end else begin
            state    <= HDRS;
            probe    <= 1'b0;
            word_idx <= '0;
          end
        end
        default: state <= HDRS;
      endcase
    end
  end

  // Stamp statistics for the RTT logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stamp_cnt  <= '0;
      last_stamp <= '0;
    end else if (stamp_hit) begin
      stamp_cnt  <= stamp_cnt + 32'd1;
      last_stamp <= ts_hold;
    end
  end

  // Output mux: head word (or the stamp) while transferring, zero otherwise.
  always_comb begin
    downstream.wr   = pop;
    downstream.ctrl = '0;
    downstream.data = '0;
    if (pop) begin
      downstream.ctrl = head_ctrl;
      downstream.data = stamp_hit ? DATA_WIDTH'(ts_hold) : head_data;
    end
  end

endmodule

// File: tb/tb_probe_stamp.sv
// Self-checking bench for probe_stamp: directed packet table, back-pressure,
// mid-packet reset, back-to-back probes and a randomized packet stream
// compared against a packet-level reference model.
module tb_probe_stamp;
  localparam int STAMP_WORD = 2;
  localparam logic [63:0] FILL = 64'h0a11223308014444;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stamp_en = 1'b0;
  logic [31:0] stamp_cnt;
  logic [63:0] last_stamp;

  probe_stamp_if #(.DATA_WIDTH(64)) upstream ();
  probe_stamp_if #(.DATA_WIDTH(64)) downstream ();

  probe_stamp dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .upstream   (upstream),
    .downstream (downstream),
    .stamp_en   (stamp_en),
    .stamp_cnt  (stamp_cnt),
    .last_stamp (last_stamp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] ctrl; logic [63:0] data; } word_t;
  typedef struct { logic [7:0] ctrl; logic [63:0] data; bit ts_hdr; bit stamp_slot; } exp_t;
  typedef struct { logic [15:0] dst; int ndata; bit en; int exp_delta; } vec_t;

  word_t       sendq[$];
  exp_t        expq[$];
  logic [63:0] stamps[$];
  int          checks = 0;
  int          failures = 0;

  // Bench cycle count since reset release: the value the stamp counter must hold.
  logic [63:0] cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 64'd0;
    else          cyc <= cyc + 64'd1;
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Driver: pushes queued words when in_rdy allows, sets out_rdy.
  bit rdy_mode = 1'b0;
  bit rdy_val = 1'b1;
  bit force_wr = 1'b0;
  int gap_pct = 0;
  word_t drv_w;
  always @(posedge clk) begin
    #1;
    downstream.rdy = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
    if (reset_n && sendq.size() > 0 && (upstream.rdy || force_wr) &&
        ($urandom_range(0, 99) >= gap_pct)) begin
      drv_w = sendq.pop_front();
      upstream.wr   = 1'b1;
      upstream.ctrl = drv_w.ctrl;
      upstream.data = drv_w.data;
      force_wr      = 1'b0;
    end else begin
      upstream.wr   = 1'b0;
      upstream.ctrl = 8'h00;
      upstream.data = 64'h0;
    end
  end

  // Monitor / scoreboard.
  logic [63:0] ts_exp = 64'd0;
  int          exp_cnt = 0;
  logic [63:0] exp_last = 64'd0;
  exp_t        mon_e;
  logic [63:0] mon_req;
  always @(negedge clk) begin
    if (reset_n) begin
      if (downstream.wr) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%h_%h required=no_word", downstream.ctrl, downstream.data);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.ts_hdr) ts_exp = cyc;
          mon_req = mon_e.stamp_slot ? ts_exp : mon_e.data;
          check64("word_ctrl", 64'(downstream.ctrl), 64'(mon_e.ctrl));
          check64("word_data", downstream.data, mon_req);
          if (mon_e.stamp_slot) begin
            exp_cnt++;
            exp_last = ts_exp;
            stamps.push_back(ts_exp);
          end
        end
      end else begin
        check64("idle_data", downstream.data, 64'h0);
      end
    end
  end

  function automatic void add_word(input logic [7:0] c, input logic [63:0] d, input bit th, input bit ss);
    word_t w;
    exp_t  e;
    w.ctrl = c; w.data = d;
    e.ctrl = c; e.data = d; e.ts_hdr = th; e.stamp_slot = ss;
    sendq.push_back(w);
    expq.push_back(e);
  endfunction

  // Reference model: the last HDR_CTRL header decides probe; data word
  // STAMP_WORD (never the EOP) carries the timestamp if stamping is enabled.
  task automatic push_pkt(input logic [15:0] dst, input int ndata, input bit en,
                          input int n_extra, input bit has_hdr, input bit rnd);
    bit          probe_m = 1'b0;
    logic [7:0]  c;
    logic [63:0] d;
    logic [15:0] xd;
    for (int i = 0; i < n_extra; i++) begin
      c  = 8'($urandom_range(1, 255));
      xd = ($urandom_range(0, 1) != 0) ? 16'h0005 : 16'h0004;
      d  = {xd, 16'($urandom), 32'($urandom)};
      if (c == 8'hFF) probe_m = (xd == 16'h0005);
      add_word(c, d, c == 8'hFF, 1'b0);
    end
    if (has_hdr) begin
      probe_m = (dst == 16'h0005);
      add_word(8'hFF, {dst, 16'h0008, 32'h0000_0040}, 1'b1, 1'b0);
    end
    for (int k = 0; k < ndata; k++) begin
      d = rnd ? {32'($urandom), 32'($urandom)} : FILL;
      add_word(8'h00, d, 1'b0, probe_m && en && (k == STAMP_WORD));
    end
    c = rnd ? 8'($urandom_range(1, 255)) : 8'h01;
    d = rnd ? {32'($urandom), 32'($urandom)} : FILL;
    add_word(c, d, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sendq.size() != 0 || expq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_drain actual=%0d_pending required=0", name, expq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  vec_t        tbl[7];
  logic [31:0] cnt0;
  logic [63:0] pc;

  initial begin
    tbl[0] = '{16'h0005, 8, 1'b1, 1};
    tbl[1] = '{16'h0004, 8, 1'b1, 0};
    tbl[2] = '{16'h0005, 8, 1'b0, 0};
    tbl[3] = '{16'h0005, 2, 1'b1, 0};
    tbl[4] = '{16'h0005, 8, 1'b1, 1};
    tbl[5] = '{16'h0005, 3, 1'b1, 1};
    tbl[6] = '{16'h0105, 8, 1'b1, 0};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check64("rst_out_wr",     64'(downstream.wr),   64'h0);
    check64("rst_out_data",   downstream.data,      64'h0);
    check64("rst_out_ctrl",   64'(downstream.ctrl), 64'h0);
    check64("rst_in_rdy",     64'(upstream.rdy),    64'h0);
    check64("rst_stamp_cnt",  64'(stamp_cnt),       64'h0);
    check64("rst_last_stamp", last_stamp,           64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check64("post_rst_in_rdy", 64'(upstream.rdy), 64'h1);

    // Directed packet table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      stamp_en = tbl[i].en;
      cnt0 = stamp_cnt;
      pc = cyc;
      push_pkt(tbl[i].dst, tbl[i].ndata, tbl[i].en, 0, 1'b1, 1'b0);
      wait_drain($sformatf("tbl%0d", i));
      check64($sformatf("tbl%0d_cnt_delta", i), 64'(stamp_cnt - cnt0), 64'(tbl[i].exp_delta));
      if (tbl[i].exp_delta != 0)
        check64($sformatf("tbl%0d_last_stamp", i), last_stamp, pc + 64'd2);
    end

    // Back-pressure after the header leaves; one extra write beyond in_rdy.
    @(negedge clk);
    stamp_en = 1'b1;
    cnt0 = stamp_cnt;
    pc = cyc;
    push_pkt(16'h0005, 8, 1'b1, 0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rdy_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check64("bp_rdy_two_buffered", 64'(upstream.rdy), 64'h1);
    @(negedge clk);
    check64("bp_rdy_fall_at_three", 64'(upstream.rdy), 64'h0);
    force_wr = 1'b1;
    repeat (7) @(negedge clk);
    check64("bp_rdy_still_low", 64'(upstream.rdy), 64'h0);
    rdy_val = 1'b1;
    wait_drain("bp");
    check64("bp_cnt_delta", 64'(stamp_cnt - cnt0), 64'h1);
    check64("bp_last_stamp", last_stamp, pc + 64'd2);

    // Asynchronous reset in the middle of a probe.
    @(negedge clk);
    push_pkt(16'h0005, 8, 1'b1, 0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sendq.delete();
    expq.delete();
    exp_cnt = 0;
    exp_last = 64'h0;
    #1;
    check64("mid_rst_out_wr",     64'(downstream.wr),   64'h0);
    check64("mid_rst_out_data",   downstream.data,      64'h0);
    check64("mid_rst_out_ctrl",   64'(downstream.ctrl), 64'h0);
    check64("mid_rst_in_rdy",     64'(upstream.rdy),    64'h0);
    check64("mid_rst_stamp_cnt",  64'(stamp_cnt),       64'h0);
    check64("mid_rst_last_stamp", last_stamp,           64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pc = cyc;
    push_pkt(16'h0005, 8, 1'b1, 0, 1'b1, 1'b0);
    wait_drain("post_rst");
    check64("post_rst_cnt", 64'(stamp_cnt), 64'h1);
    check64("post_rst_last_stamp", last_stamp, pc + 64'd2);

    // Back-to-back probes with no gap: headers 10 cycles apart.
    @(negedge clk);
    stamps.delete();
    cnt0 = stamp_cnt;
    pc = cyc;
    push_pkt(16'h0005, 8, 1'b1, 0, 1'b1, 1'b1);
    push_pkt(16'h0005, 8, 1'b1, 0, 1'b1, 1'b1);
    wait_drain("b2b");
    check64("b2b_cnt_delta", 64'(stamp_cnt - cnt0), 64'h2);
    check64("b2b_stamp_count", 64'(stamps.size()), 64'h2);
    if (stamps.size() == 2)
      check64("b2b_spacing", stamps[1] - stamps[0], 64'd10);
    check64("b2b_last_stamp", last_stamp, pc + 64'd12);

    // Randomized packet stream with random gaps and back-pressure.
    rdy_mode = 1'b1;
    gap_pct = 20;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      stamp_en = ($urandom_range(0, 1) != 0);
      for (int p = 0; p < 10; p++)
        push_pkt(($urandom_range(0, 1) != 0) ? 16'h0005 : 16'h0004,
                 $urandom_range(1, 6), stamp_en, $urandom_range(0, 2),
                 $urandom_range(0, 3) != 0, 1'b1);
      wait_drain($sformatf("rnd%0d", b));
      check64($sformatf("rnd%0d_stamp_cnt", b), 64'(stamp_cnt), 64'(exp_cnt));
      check64($sformatf("rnd%0d_last_stamp", b), last_stamp, exp_last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
